divider_seq: RTL and testbench

Multi-cycle radix-2 restoring divider with its own sequencing FSM, serving the MIPS DIV/DIVU instructions in the execute stage. It accepts operands and a start request from the EX stage and holds the pipeline stall line until the result is ready. It then presents the 64-bit {remainder, quotient} pair for the HI/LO write. It runs alongside the combinational ALU, which handles every other arithmetic op in one cycle.

---
 rtl/divider_seq.sv | 134 +++++++++++++
 tb/tb_divider_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/divider_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Takes one quotient bit per cycle and presents {remainder, quotient} for the HI/LO write.
//
// Handshake: start_i is a level request that EX holds high, with operands
// stable, until it sees ready_o. While the request is pending and no result is
// available, stall_o stays high. ready_o is high in DONE, and the result is
// consumed in that cycle. The request must then drop for one cycle before the
// next start is accepted. annul_i overrides everything and returns to IDLE.
module divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [2*WIDTH:0] work;   // {upper part (WIDTH+1), dividend/quotient bits (WIDTH)}
  logic [WIDTH-1:0] dvs;    // |divisor| captured at start
  logic             neg_q;  // negate quotient at the end
  logic             neg_r;  // negate remainder at the end
  logic [CW-1:0]    cnt;

  // Operand conditioning at the start edge: magnitudes and sign flags
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    a_neg = signed_i & dividend_i[WIDTH-1];
    b_neg = signed_i & divisor_i[WIDTH-1];
    // The most negative value maps onto itself, which is its correct magnitude when read unsigned.
    a_abs = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_abs = b_neg ? (~divisor_i + 1'b1) : divisor_i;
  end

  // One restoring iteration: shift, trial subtract, keep the difference when there is no borrow
  logic [2*WIDTH:0] shifted;
  logic [WIDTH+1:0] diff;      // WIDTH+1-bit trial plus a borrow bit
  logic [2*WIDTH:0] work_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    shifted   = work << 1;
    diff      = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvs};
    work_next = shifted;
    if (!diff[WIDTH+1]) begin
      work_next = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end
    q_fix = neg_q ? (~work_next[WIDTH-1:0] + 1'b1) : work_next[WIDTH-1:0];
    r_fix = neg_r ? (~work_next[2*WIDTH-1:WIDTH] + 1'b1) : work_next[2*WIDTH-1:WIDTH];
  end

  // Sequencing FSM with registered result/ready; annul_i has priority over every state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      work     <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              state <= BYZERO;
            end else begin
              state <= BUSY;
              work  <= {{(WIDTH+1){1'b0}}, a_abs};
              dvs   <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= '0;
            end
          end
        end
        BYZERO: begin
          state    <= DONE;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        BUSY: begin
          work <= work_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state    <= DONE;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end
        end
        DONE: begin
          if (!start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall while a request is pending and no result is on offer; forced low during reset
  always_comb begin
    stall_o   = resetn & start_i & ~annul_i & (state != DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: directed MIPS cases, divide-by-zero, annul, mid-run reset
// and randomized operands against an arithmetic reference model.
module tb_divider_seq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;
  logic [1:0]  state_dbg;

  int compared = 0;
  int mismatched = 0;

  divider_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_o    (stall_o),
    .state_dbg  (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference: plain integer division, truncating toward zero; divisor 0 gives 0
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [63:0] last_result;

  // One full request: hold start until ready, check latency, stall length, result, then release
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input logic scramble);
    int n;
    int stalls;
    int exp_lat;
    exp_lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    signed_i = sgn; dividend_i = a; divisor_i = b; start_i = 1'b1;
    n = 0; stalls = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      #1;
      if (stall_o === 1'b1) stalls++;
      @(negedge clk);
      n++;
      if (scramble) begin
        signed_i = 1'($urandom_range(0, 1)); dividend_i = $urandom; divisor_i = $urandom;
      end
    end
    check({tag, " latency"}, 64'(n), 64'(exp_lat));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(exp_lat));
    check({tag, " result"}, result_o, exp);
    #1;
    check({tag, " stall_in_done"}, 64'(stall_o), 64'd0);
    last_result = result_o;
    start_i = 1'b0;
    @(negedge clk);
    check({tag, " ready_drop"}, 64'(ready_o), 64'd0);
    check({tag, " result_hold"}, result_o, exp);
  endtask

  initial begin
    int rdy_seen;
    logic        rs;
    logic [31:0] ra, rb;

    // Reset
    resetn = 1'b0; signed_i = 1'b0; dividend_i = '0; divisor_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset result", result_o, 64'd0);
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Directed cases
    do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    do_div("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    do_div("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0);
    do_div("uffff_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b0);
    do_div("smin_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0);
    do_div("div0", 1'b0, 32'h1234, 32'd0, 64'd0, 1'b0);
    do_div("u100_7_scr", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);

    // Annul mid-iteration
    @(negedge clk);
    signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    #1;
    check("annul stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    check("annul state", 64'(state_dbg), 64'd0);
    check("annul result_kept", result_o, last_result);
    rdy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) rdy_seen++;
    end
    check("annul no_ready", 64'(rdy_seen), 64'd0);
    do_div("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

    // Reset mid-operation
    @(negedge clk);
    signed_i = 1'b1; dividend_i = 32'hFFFFFFF9; divisor_i = 32'd2; start_i = 1'b1;
    repeat (21) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("mreset result", result_o, 64'd0);
    check("mreset ready", 64'(ready_o), 64'd0);
    check("mreset stall", 64'(stall_o), 64'd0);
    check("mreset state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    start_i = 1'b0; resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset state", 64'(state_dbg), 64'd0);
    check("post_reset stall", 64'(stall_o), 64'd0);
    check("post_reset ready", 64'(ready_o), 64'd0);
    do_div("after_reset", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

    // Randomized operands against the model
    for (int k = 0; k < 24; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = 32'd0;
        2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if (k % 6 == 5) ra = 32'h80000000;
      do_div("random", rs, ra, rb, model(rs, ra, rb), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
